// File: rtl/imm_pack.sv
// rtl/imm_pack.sv - immediate range check and instruction-field packer with a one-slot output register
// Optional error counter: define IMM_PACK_ERRCNT_EN.
module imm_pack #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      imm_i,
  input  logic [2:0]       sext_op_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [24:0]      inst_o,
  output logic             err_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t      state_q, state_d;
  logic [24:0] inst_q, inst_d;
  logic        err_q, err_d;
  logic [24:0] pk_inst;
  logic        pk_err;
  logic        accept;
  logic        pop;

  // Bit positions are relative to inst[7]: inst_o[k] carries inst[k+7].
  always_comb begin
    pk_inst = '0;
    pk_err  = 1'b0;
    case (sext_op_i)
      3'b000: begin
        pk_err         = !((&imm_i[31:11]) || !(|imm_i[31:11]));
        pk_inst[24:13] = imm_i[11:0];
      end
      3'b001: begin
        pk_err         = !((&imm_i[31:11]) || !(|imm_i[31:11]));
        pk_inst[24:18] = imm_i[11:5];
        pk_inst[4:0]   = imm_i[4:0];
      end
      3'b010: begin
        pk_err         = !((&imm_i[31:12]) || !(|imm_i[31:12])) || imm_i[0];
        pk_inst[24]    = imm_i[12];
        pk_inst[23:18] = imm_i[10:5];
        pk_inst[4:1]   = imm_i[4:1];
        pk_inst[0]     = imm_i[11];
      end
      3'b011: begin
        pk_err         = |imm_i[11:0];
        pk_inst[24:5]  = imm_i[31:12];
      end
      3'b100: begin
        pk_err         = !((&imm_i[31:20]) || !(|imm_i[31:20])) || imm_i[0];
        pk_inst[24]    = imm_i[20];
        pk_inst[23:14] = imm_i[10:1];
        pk_inst[13]    = imm_i[11];
        pk_inst[12:5]  = imm_i[19:12];
      end
      default: pk_err = 1'b1;
    endcase
    if (pk_err) begin
      pk_inst = '0;
    end
  end

  assign in_ready_o = (state_q == EMPTY) || out_ready_i;
  assign accept     = in_valid_i && in_ready_o;
  assign pop        = (state_q == FULL) && out_ready_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= EMPTY;
      inst_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    inst_d  = inst_q;
    err_d   = err_q;
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (pop && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
    if (accept) begin
      inst_d = pk_inst;
      err_d  = pk_err;
    end
  end

  always_comb begin
    out_valid_o = (state_q == FULL);
    inst_o      = inst_q;
    err_o       = err_q;
  end

`ifdef IMM_PACK_ERRCNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Saturate rather than wrap so a long error burst never reads as few errors.
  always_comb begin
    cnt_d = cnt_q;
    if (accept && pk_err && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign err_cnt_o = cnt_q;
`else
  assign err_cnt_o = '0;
`endif

endmodule

// File: doc/imm_pack.md
# imm_pack

Immediate packer: the inverse of the immediate sign-extension path. It accepts a 32-bit immediate value and an immediate format code, checks that the value fits the format, and scatters it into the instruction-word immediate fields (inst[31:7]). It sits behind a valid/ready handshake with a registered output stage, so it can feed the instruction assembler / self-check generator at one word per cycle under back-pressure.

## Interface
- Parameters:
- CNT_W, 8, width of the saturating error counter.
- Ports:
- clk_i  in  1  clock; all state changes on rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- in_valid_i  in  1  input word present.
- in_ready_o  out  1  block can accept the input this cycle.
- imm_i  in  32  immediate value (two's complement, byte offset for B/J).
- sext_op_i  in  3  format: 000 I, 001 S, 010 B, 011 U, 100 J; 101-111 invalid (same codes as param.vh).
- out_valid_o  out  1  packed result present.
- out_ready_i  in  1  consumer takes the result this cycle.
- inst_o  out  25  packed fields, inst_o[k] = inst[k+7]; non-immediate bits 0.
- err_o  out  1  result is unrepresentable; inst_o is 0 when set.
- err_cnt_o  out  CNT_W  saturating count of accepted words with err (see Configuration).

## Operation
- Range rules (err if violated, or if op invalid):
- I, S: imm_i[31:11] all equal.
- B: imm_i[31:12] all equal and imm_i[0]==0.
- U: imm_i[11:0]==0.
- J: imm_i[31:20] all equal and imm_i[0]==0.
- Packing (inst bit <- imm bit):
- I: [31:20]<-[11:0].
- S: [31:25]<-[11:5], [11:7]<-[4:0].
- B: [31]<-[12], [30:25]<-[10:5], [11:8]<-[4:1], [7]<-[11].
- U: [31:12]<-[31:12].
- J: [31]<-[20], [30:21]<-[10:1], [20]<-[11], [19:12]<-[19:12].
- Output stage: single register slot, states EMPTY (out_valid_o=0) and FULL (out_valid_o=1).
- in_ready_o = !out_valid_o || out_ready_i (combinational, no dependency on in_valid_i).
- EMPTY + accept -> FULL. FULL + pop, no accept -> EMPTY. FULL + pop + accept -> FULL with new word. FULL, no pop -> hold.
- err_cnt_o increments by 1 per accepted word with err; saturates at 2^CNT_W-1, never wraps.

## Timing
- Reset (async, immediate): out_valid_o=0, inst_o=0, err_o=0, err_cnt_o=0; in_ready_o=1 once reset released.
- Accept on rising edge where in_valid_i && in_ready_o; result visible on out_valid_o/inst_o/err_o after that edge (latency 1 cycle).
- Throughput 1 word/cycle while out_ready_i=1.
- While out_valid_o && !out_ready_i: inst_o, err_o held stable; in_ready_o=0; inputs ignored.
- Reset asserted mid-transfer: held word discarded, no partial output after release.
- imm_i/sext_op_i sampled only on accept edges; other cycles are don't-care.

## Configuration
- IMM_PACK_ERRCNT_EN defined: err_cnt_o counter implemented as above.
- Undefined: counter not built; err_cnt_o tied to 0; packing, err_o and handshake unchanged.

## Test plan
- I, imm_i=0xFFFFFFFF -> one cycle later out_valid_o=1, inst_o=0x1FFE000, err_o=0.
- S, imm_i=0x000007FF -> inst_o=0x0FC001F; B, imm_i=0x00000800 -> inst_o=0x0000001; B, imm_i=0x00001001 -> err_o=1, inst_o=0, err_cnt_o=1.
- U, imm_i=0x12345000 -> inst_o=0x02468A0; U, imm_i=0x12345001 -> err_o=1; op=101 -> err_o=1.
- J, imm_i=0xFFFFFFFE -> inst_o=0x1FFFFE0; J, imm_i=0x00100000 -> err_o=1.
- Back-pressure: stream 4 words with out_ready_i low 3 cycles mid-stream -> in_ready_o=0 while stalled, outputs held, all 4 words delivered in order, none lost/duplicated; with out_ready_i=1, 1 word/cycle.
- Reset while FULL -> out_valid_o=0 immediately, err_cnt_o=0; 300 error words with CNT_W=8 -> err_cnt_o=255; without IMM_PACK_ERRCNT_EN err_cnt_o stays 0.
